// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
//
// Hazard / forwarding unit for the pipelined RV32 core. The destination
// registers of the DEPTH instructions in flight after decode are kept in a
// shift-register scoreboard (entry 0 = stage right after decode,
// entry DEPTH-1 = writeback). From that scoreboard and the decode-slot
// operands it produces the operand bypass selects, the load-use stall and a
// saturating count of stall cycles.
//
// Ports
//   clk           clock
//   reset         asynchronous active-high reset
//   id_valid      decode slot holds a real instruction
//   id_rs1/rs2    decode source registers
//   id_use_rs1/2  instruction actually reads rs1 / rs2
//   id_rd         decode destination register
//   id_reg_wr     instruction writes rd
//   id_is_load    instruction is a load
//   flush         kill the decode instruction (taken branch)
//   ext_stall     freeze the whole pipeline (memory wait)
//   fwd_sel_a/b   0 = register file, k+1 = forward from scoreboard entry k
//   hazard_stall  hold fetch/decode and bubble entry 0 (combinational)
//   stall_cnt     saturating count of cycles hazard_stall took effect
// -----------------------------------------------------------------------------
module hazard_scoreboard #(
   parameter int DEPTH    = 2,
   parameter int LOAD_LAT = 1,
   parameter int REG_AW   = 5,
   parameter int CNT_W    = 16
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         id_valid,
   input  logic [REG_AW-1:0]            id_rs1,
   input  logic [REG_AW-1:0]            id_rs2,
   input  logic                         id_use_rs1,
   input  logic                         id_use_rs2,
   input  logic [REG_AW-1:0]            id_rd,
   input  logic                         id_reg_wr,
   input  logic                         id_is_load,
   input  logic                         flush,
   input  logic                         ext_stall,
   output logic [$clog2(DEPTH+1)-1:0]   fwd_sel_a,
   output logic [$clog2(DEPTH+1)-1:0]   fwd_sel_b,
   output logic                         hazard_stall,
   output logic [CNT_W-1:0]             stall_cnt
);

   localparam int SEL_W = $clog2(DEPTH+1);

   // Scoreboard entries: valid, destination, writes-rd, is-load.
   logic              ent_v_r  [DEPTH];
   logic [REG_AW-1:0] ent_rd_r [DEPTH];
   logic              ent_wr_r [DEPTH];
   logic              ent_ld_r [DEPTH];

   logic [SEL_W-1:0]  sel_a_s;
   logic [SEL_W-1:0]  sel_b_s;
   logic              raw_a_s;
   logic              raw_b_s;
   logic              qual_a_s;
   logic              qual_b_s;
   logic              bubble_s;

   // An operand can only match when it is really read and is not x0.
   assign qual_a_s = id_valid & id_use_rs1 & (id_rs1 != {REG_AW{1'b0}});
   assign qual_b_s = id_valid & id_use_rs2 & (id_rs2 != {REG_AW{1'b0}});

   // Operand lookup: scan oldest to youngest so the youngest match is the one
   // left standing. A load that has not yet reached LOAD_LAT cannot forward,
   // so it turns into a RAW hazard with select 0.
   always_comb begin
      sel_a_s = {SEL_W{1'b0}};
      sel_b_s = {SEL_W{1'b0}};
      raw_a_s = 1'b0;
      raw_b_s = 1'b0;
      for (int k = DEPTH-1; k >= 0; k--) begin
         if (qual_a_s && ent_v_r[k] && ent_wr_r[k] && (ent_rd_r[k] == id_rs1)) begin
            if (ent_ld_r[k] && (k < LOAD_LAT)) begin
               raw_a_s = 1'b1;
               sel_a_s = {SEL_W{1'b0}};
            end else begin
               raw_a_s = 1'b0;
               sel_a_s = SEL_W'(k + 1);
            end
         end else begin
            raw_a_s = raw_a_s;
            sel_a_s = sel_a_s;
         end
         if (qual_b_s && ent_v_r[k] && ent_wr_r[k] && (ent_rd_r[k] == id_rs2)) begin
            if (ent_ld_r[k] && (k < LOAD_LAT)) begin
               raw_b_s = 1'b1;
               sel_b_s = {SEL_W{1'b0}};
            end else begin
               raw_b_s = 1'b0;
               sel_b_s = SEL_W'(k + 1);
            end
         end else begin
            raw_b_s = raw_b_s;
            sel_b_s = sel_b_s;
         end
      end
   end

   // Output drive: a flush kills the decode instruction, so it cannot stall.
   always_comb begin
      fwd_sel_a = sel_a_s;
      fwd_sel_b = sel_b_s;
      if (flush) begin
         hazard_stall = 1'b0;
      end else begin
         hazard_stall = raw_a_s | raw_b_s;
      end
   end

   assign bubble_s = flush | hazard_stall | ~id_valid;

   // Scoreboard shift: freeze on ext_stall, otherwise advance one stage and
   // load entry 0 with the decode instruction or a bubble.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < DEPTH; k++) begin
            ent_v_r[k]  <= 1'b0;
            ent_rd_r[k] <= {REG_AW{1'b0}};
            ent_wr_r[k] <= 1'b0;
            ent_ld_r[k] <= 1'b0;
         end
      end else if (!ext_stall) begin
         for (int k = DEPTH-1; k > 0; k--) begin
            ent_v_r[k]  <= ent_v_r[k-1];
            ent_rd_r[k] <= ent_rd_r[k-1];
            ent_wr_r[k] <= ent_wr_r[k-1];
            ent_ld_r[k] <= ent_ld_r[k-1];
         end
         if (bubble_s) begin
            ent_v_r[0]  <= 1'b0;
            ent_rd_r[0] <= {REG_AW{1'b0}};
            ent_wr_r[0] <= 1'b0;
            ent_ld_r[0] <= 1'b0;
         end else begin
            ent_v_r[0]  <= 1'b1;
            ent_rd_r[0] <= id_rd;
            // x0 is never recorded as a writer, so it can never match.
            ent_wr_r[0] <= id_reg_wr & (id_rd != {REG_AW{1'b0}});
            ent_ld_r[0] <= id_is_load;
         end
      end
   end

   // Stall counter: counts stall cycles that actually advanced, saturating.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt <= {CNT_W{1'b0}};
      end else if (hazard_stall && !ext_stall && (stall_cnt != {CNT_W{1'b1}})) begin
         stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

   localparam int DEPTH    = 2;
   localparam int LOAD_LAT = 1;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       id_valid = 1'b0;
   logic [4:0] id_rs1 = 5'd0;
   logic [4:0] id_rs2 = 5'd0;
   logic       id_use_rs1 = 1'b0;
   logic       id_use_rs2 = 1'b0;
   logic [4:0] id_rd = 5'd0;
   logic       id_reg_wr = 1'b0;
   logic       id_is_load = 1'b0;
   logic       flush = 1'b0;
   logic       ext_stall = 1'b0;

   logic [1:0]  fwd_sel_a, fwd_sel_b, fwd_sel_a2, fwd_sel_b2;
   logic        hazard_stall, hazard_stall2;
   logic [15:0] stall_cnt;
   logic [1:0]  stall_cnt2;

   int n_tests = 0;
   int n_fail  = 0;
   bit run_cmp = 1'b0;

   always #5 clk = ~clk;

   hazard_scoreboard #(.DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT), .REG_AW(5), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_reg_wr(id_reg_wr),
      .id_is_load(id_is_load), .flush(flush), .ext_stall(ext_stall),
      .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b), .hazard_stall(hazard_stall),
      .stall_cnt(stall_cnt));

   hazard_scoreboard #(.DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT), .REG_AW(5), .CNT_W(2)) dut_sat (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_reg_wr(id_reg_wr),
      .id_is_load(id_is_load), .flush(flush), .ext_stall(ext_stall),
      .fwd_sel_a(fwd_sel_a2), .fwd_sel_b(fwd_sel_b2), .hazard_stall(hazard_stall2),
      .stall_cnt(stall_cnt2));

   task automatic chk(input string nm, input longint act, input longint exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   // In-flight instructions, index 0 = youngest (just past decode).
   typedef struct { bit v; int rd; bit wr; bit ld; } rec_t;
   rec_t pipe[$];
   int   m_stalls = 0;

   // Youngest writer of src decides: a too-young load is a hazard, anything else forwards.
   function automatic void look(input int src, input bit use_it, output int sel, output bit raw);
      sel = 0;
      raw = 1'b0;
      if (!id_valid || !use_it || src == 0) return;
      foreach (pipe[k]) begin
         if (pipe[k].v && pipe[k].wr && pipe[k].rd == src) begin
            if (pipe[k].ld && k < LOAD_LAT) raw = 1'b1;
            else sel = k + 1;
            return;
         end
      end
   endfunction

   function automatic bit model_stall();
      int sa, sb;
      bit ra, rb;
      look(int'(id_rs1), id_use_rs1, sa, ra);
      look(int'(id_rs2), id_use_rs2, sb, rb);
      return (ra || rb) && !flush;
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         rec_t e;
         e = '{v: 1'b0, rd: 0, wr: 1'b0, ld: 1'b0};
         pipe.delete();
         for (int i = 0; i < DEPTH; i++) pipe.push_back(e);
         m_stalls = 0;
      end else if (!ext_stall) begin
         rec_t e;
         bit hz;
         hz = model_stall();
         if (hz) m_stalls++;
         if (flush || hz || !id_valid) e = '{v: 1'b0, rd: 0, wr: 1'b0, ld: 1'b0};
         else e = '{v: 1'b1, rd: int'(id_rd), wr: id_reg_wr && id_rd != 5'd0, ld: id_is_load};
         pipe.push_front(e);
         void'(pipe.pop_back());
      end
   end

   // Every-cycle comparison of both instances against the model.
   always @(negedge clk) begin
      if (run_cmp) begin
         int sa, sb;
         bit ra, rb, hz;
         look(int'(id_rs1), id_use_rs1, sa, ra);
         look(int'(id_rs2), id_use_rs2, sb, rb);
         hz = (ra || rb) && !flush;
         chk("cmp_sel_a", fwd_sel_a, sa);
         chk("cmp_sel_b", fwd_sel_b, sb);
         chk("cmp_stall", hazard_stall, hz);
         chk("cmp_cnt", stall_cnt, (m_stalls > 65535) ? 65535 : m_stalls);
         chk("cmp_sel_a_sat", fwd_sel_a2, sa);
         chk("cmp_stall_sat", hazard_stall2, hz);
         chk("cmp_cnt_sat", stall_cnt2, (m_stalls > 3) ? 3 : m_stalls);
      end
   end

   // One decode cycle: drive just after the edge, return at the following negedge.
   task automatic cyc(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                      input int rd, input bit wr, input bit ld, input bit fl, input bit ext);
      @(posedge clk);
      #1;
      id_valid = v; id_rs1 = 5'(rs1); id_use_rs1 = u1; id_rs2 = 5'(rs2); id_use_rs2 = u2;
      id_rd = 5'(rd); id_reg_wr = wr; id_is_load = ld; flush = fl; ext_stall = ext;
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      run_cmp = 1'b1;
      #1 reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("reset_sel_a", fwd_sel_a, 0);
      chk("reset_stall", hazard_stall, 0);
      chk("reset_cnt", stall_cnt, 0);

      // 1: ALU forwarding from entry 0, then entry 1
      cyc(1, 0, 0, 0, 0, 5, 1, 0, 0, 0);        // add x5
      cyc(1, 5, 1, 0, 0, 9, 1, 0, 0, 0);        // reads x5
      chk("fwd_e0_sel_a", fwd_sel_a, 1);
      chk("fwd_e0_stall", hazard_stall, 0);
      cyc(1, 5, 1, 0, 0, 10, 1, 0, 0, 0);       // reads x5 one further back
      chk("fwd_e1_sel_a", fwd_sel_a, 2);

      // 2: load-use, single stall cycle then forward from entry 1
      cyc(1, 0, 0, 0, 0, 7, 1, 1, 0, 0);        // lw x7
      cyc(1, 0, 0, 7, 1, 11, 1, 0, 0, 0);
      chk("ldu_stall", hazard_stall, 1);
      chk("ldu_sel_b", fwd_sel_b, 0);
      cyc(1, 0, 0, 7, 1, 11, 1, 0, 0, 0);       // held decode
      chk("ldu_after_stall", hazard_stall, 0);
      chk("ldu_after_sel_b", fwd_sel_b, 2);
      chk("ldu_cnt", stall_cnt, 1);

      // 3: youngest writer wins
      cyc(1, 0, 0, 0, 0, 3, 1, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 3, 1, 0, 0, 0);
      cyc(1, 3, 1, 0, 0, 0, 0, 0, 0, 0);
      chk("youngest_sel_a", fwd_sel_a, 1);

      // 4: flush beats the hazard and leaves a bubble in entry 0
      cyc(1, 0, 0, 0, 0, 7, 1, 1, 0, 0);        // lw x7
      cyc(1, 0, 0, 7, 1, 7, 1, 0, 1, 0);        // dependent, flushed, writes x7
      chk("flush_stall", hazard_stall, 0);
      cyc(1, 0, 0, 7, 1, 0, 0, 0, 0, 0);
      chk("flush_bubble_sel_b", fwd_sel_b, 2);
      chk("flush_cnt", stall_cnt, 1);

      // 5: hazard held under ext_stall
      cyc(1, 0, 0, 0, 0, 12, 1, 1, 0, 0);       // lw x12
      for (int i = 0; i < 3; i++) begin
         cyc(1, 12, 1, 0, 0, 13, 1, 0, 0, 1);
         chk("ext_stall_hz", hazard_stall, 1);
         chk("ext_stall_cnt", stall_cnt, 1);
      end
      cyc(1, 12, 1, 0, 0, 13, 1, 0, 0, 0);
      chk("ext_release_hz", hazard_stall, 1);
      cyc(1, 12, 1, 0, 0, 13, 1, 0, 0, 0);
      chk("ext_release_sel_a", fwd_sel_a, 2);
      chk("ext_release_cnt", stall_cnt, 2);

      // 6: x0 never matches
      cyc(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);        // write x0
      cyc(1, 0, 1, 0, 1, 0, 1, 1, 0, 0);        // read x0, also lw x0
      chk("x0_sel_a", fwd_sel_a, 0);
      chk("x0_sel_b", fwd_sel_b, 0);
      cyc(1, 0, 1, 0, 1, 14, 1, 0, 0, 0);
      chk("x0_ld_stall", hazard_stall, 0);

      // saturation: three more load-use stalls (5 total)
      for (int i = 0; i < 3; i++) begin
         cyc(1, 0, 0, 0, 0, 20 + i, 1, 1, 0, 0);
         cyc(1, 20 + i, 1, 0, 0, 25, 1, 0, 0, 0);
         chk("sat_stall", hazard_stall, 1);
         cyc(1, 20 + i, 1, 0, 0, 25, 1, 0, 0, 0);
      end
      chk("sat_cnt16", stall_cnt, 5);
      chk("sat_cnt2", stall_cnt2, 3);

      // reset in the middle of a stall
      cyc(1, 0, 0, 0, 0, 30, 1, 1, 0, 0);
      cyc(1, 30, 1, 0, 0, 31, 1, 0, 0, 0);
      chk("pre_reset_stall", hazard_stall, 1);
      #2 reset = 1'b1;
      #1;
      chk("async_reset_stall", hazard_stall, 0);
      chk("async_reset_cnt", stall_cnt, 0);
      chk("async_reset_sel_a", fwd_sel_a, 0);
      @(negedge clk);
      reset = 1'b0;
      cyc(1, 30, 1, 0, 0, 31, 1, 0, 0, 0);
      chk("post_reset_stall", hazard_stall, 0);

      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      run_cmp = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised hazard/forwarding unit for the pipelined RV32 core; replaces the fixed single-stage forwarding decode inside the controller.
- Tracks destination registers of the DEPTH instructions in flight past decode in a shift-register scoreboard.
- Generates per-operand forwarding selects, load-use stall, and a saturating stall counter.
- Sits beside the controller; its outputs drive the operand bypass muxes and the preg_1/preg_2 stall inputs.

Parameters:
DEPTH, 2, in-flight stages tracked after decode (entry 0 = stage right after decode; entry DEPTH-1 = writeback).
LOAD_LAT, 1, load data forwardable only from entry index >= LOAD_LAT.
REG_AW, 5, register address width.
CNT_W, 16, stall counter width.

Ports:
clk  in  1  clock
reset  in  1  async active-high reset
id_valid  in  1  decode slot holds a real instruction
id_rs1  in  REG_AW  decode source 1
id_rs2  in  REG_AW  decode source 2
id_use_rs1  in  1  instruction reads rs1
id_use_rs2  in  1  instruction reads rs2
id_rd  in  REG_AW  decode destination
id_reg_wr  in  1  instruction writes rd
id_is_load  in  1  instruction is a load
flush  in  1  kill decode instruction (taken branch)
ext_stall  in  1  freeze whole pipeline (memory wait)
fwd_sel_a  out  $clog2(DEPTH+1)  0 = reg file, k+1 = forward from entry k
fwd_sel_b  out  $clog2(DEPTH+1)  same for rs2
hazard_stall  out  1  hold fetch/decode, bubble into entry 0
stall_cnt  out  CNT_W  cycles hazard_stall was asserted

Behaviour:
- State: entries e[0..DEPTH-1], each {v, rd, wr, ld}; stall_cnt register.
- Reset (async): all v=0, stall_cnt=0; outputs therefore fwd_sel_a=fwd_sel_b=0, hazard_stall=0.
- Match for operand X (rs1/rs2), combinational from state and decode inputs:
  - Youngest (lowest k) entry with v & wr & rd==X & X!=0 & id_use_X & id_valid.
  - Older matches are ignored.
  - No match -> sel 0.
  - Match with ld=1 and k<LOAD_LAT -> raw hazard for X; sel forced 0.
  - Otherwise sel = k+1.
- hazard_stall = (raw hazard on rs1 or rs2) & ~flush. Combinational, zero latency.
- Update at posedge clk, priority order:
  1. ext_stall=1: all entries and stall_cnt hold. hazard_stall output is still computed.
  2. Else shift: e[k+1] <= e[k] for k<DEPTH-1; e[DEPTH-1] content drops out.
  3. e[0] <= bubble (v=0) if flush | hazard_stall | ~id_valid.
  4. Else e[0] <= {1, id_rd, id_reg_wr & (id_rd!=0), id_is_load}.
- stall_cnt: increments when hazard_stall=1 and ext_stall=0; saturates at all-ones, no wrap.
- rd==x0: never matches, never recorded as writer.
- flush and hazard in the same cycle: flush wins. hazard_stall=0, bubble inserted.
- The load resolves automatically: after LOAD_LAT stall cycles it reaches entry LOAD_LAT and forwarding takes over. No internal state machine is needed beyond the shift.
- Reset mid-stall: scoreboard clears; hazard_stall drops the same cycle and is not retained.

Test Plan:
1. DEPTH=2, LOAD_LAT=1. Issue add x5 (non-load), next cycle decode reads rs1=x5 -> fwd_sel_a=1, hazard_stall=0. One cycle later, with an independent instruction between, a decode reading x5 -> fwd_sel_a=2.
2. Issue lw x7, next decode reads rs2=x7 -> hazard_stall=1 for exactly 1 cycle, then fwd_sel_b=2, stall_cnt=1.
3. Writer x3 at entry 1 and newer writer x3 at entry 0, decode reads x3 -> fwd_sel_a=1 (youngest wins).
4. lw x7 followed by a dependent decode with flush=1 in the same cycle -> hazard_stall=0, e[0] bubble, stall_cnt unchanged.
5. Hazard pending with ext_stall=1 for 3 cycles -> entries frozen, hazard_stall=1 throughout, stall_cnt unchanged. After release, stall_cnt +1 and forwarding resolves.
6. Writes to x0, and decode reading x0 -> fwd_sel 0, no stall. CNT_W=2 with 5 forced stalls -> stall_cnt=3. Assert reset mid-sequence -> all outputs 0 asynchronously.
